saph_fpu_arbiter: RTL and testbench

// - Shares one pipelined FPU between GPUS requesters using round-robin arbitration.
// - Records the GPU ID of every issued operation in an in-order tag queue.
// - Routes each FPU result strobe back to the GPU that issued that operation.
// - Sits between the GPU cores' FP request ports and the single shared FPU instance.

---
 rtl/saph_fpu_pkg.sv | 44 ++++
 rtl/saph_fpu_tagq.sv | 51 +++++
 rtl/saph_fpu_arbiter.sv | 101 ++++++++++
 tb/tb_saph_fpu_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/saph_fpu_pkg.sv
// Shared types and helpers for the FPU arbiter slice.
//   float_t    : default-width float word
//   fpu_mode_t : 2-bit rounding mode
//   gpu_id_t   : requester index, sized for the largest supported GPU count
//   rr_pick    : round-robin winner search (valid bit + index)
package saph_fpu_pkg;

    localparam int MAX_GPUS = 16;
    localparam int ID_W     = $clog2(MAX_GPUS);
    localparam int FW_DEF   = 32;

    typedef logic [FW_DEF-1:0] float_t;
    typedef logic [1:0]        fpu_mode_t;
    // The package is not parameterised, so the ID is wide enough for any
    // legal GPU count; unused upper bits simply stay zero.
    typedef logic [ID_W-1:0]   gpu_id_t;

    typedef struct packed {
        logic    vld;
        gpu_id_t idx;
    } rr_pick_t;

    // First set bit of req scanning ptr, ptr+1, ... modulo n (n <= MAX_GPUS,
    // ptr < n). Since both ptr and the offset are below n, one conditional
    // subtraction implements the wrap.
    function automatic rr_pick_t rr_pick(input logic [MAX_GPUS-1:0] req,
                                         input gpu_id_t             ptr,
                                         input int                  n);
        rr_pick_t r;
        int       idx;
        r.vld = 1'b0;
        r.idx = '0;
        for (int k = 0; k < MAX_GPUS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !r.vld && req[idx[ID_W-1:0]]) begin
                r.vld = 1'b1;
                r.idx = gpu_id_t'(idx);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/saph_fpu_tagq.sv
// In-order tag FIFO holding the GPU ID of every issued, unreturned FPU op.
//   clk, rst_n : clock, async active-low reset (empties the queue)
//   push/push_id : append an ID (caller never pushes when full without popping)
//   pop          : drop the head entry
//   head_id      : oldest ID
//   full/empty   : occupancy flags
//   count        : number of stored IDs, 0..DEPTH
module saph_fpu_tagq
    import saph_fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  gpu_id_t                  push_id,
    input  logic                     pop,
    output gpu_id_t                  head_id,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry an extra MSB so full and empty are distinguishable.
    logic [AW:0] wr_ptr, rd_ptr;
    gpu_id_t     mem [DEPTH];

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_id = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // When full with a simultaneous pop, the write lands on the head slot;
    // the head was already read combinationally this cycle, so this is safe.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_id;
    end

endmodule

// File: rtl/saph_fpu_arbiter.sv
// Round-robin arbiter sharing one pipelined FPU between GPUS requesters.
//   clk, rst_n            : clock, async active-low reset
//   req_trig/req_ready    : per-GPU request valid / grant (one-hot or zero)
//   req_lhs/rhs/mode      : per-GPU operands, GPU i at [i*W +: W]
//   res_trig/res_val      : per-GPU result strobe, broadcast result word
//   fpu_d_*               : issue port to the FPU
//   fpu_q_trig/fpu_q_res  : FPU result return (in issue order)
//   inflight              : issued, unreturned op count
//   err_orphan            : sticky, a result came back with no tag queued
module saph_fpu_arbiter
    import saph_fpu_pkg::*;
#(
    parameter int GPUS     = 1,
    parameter int MAX_INFL = 4,
    parameter int FW       = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [GPUS-1:0]             req_trig,
    output logic [GPUS-1:0]             req_ready,
    input  logic [GPUS*FW-1:0]          req_lhs,
    input  logic [GPUS*FW-1:0]          req_rhs,
    input  logic [GPUS*2-1:0]           req_mode,
    output logic [GPUS-1:0]             res_trig,
    output logic [FW-1:0]               res_val,
    output logic                        fpu_d_trig,
    input  logic                        fpu_d_ready,
    output logic [FW-1:0]               fpu_d_lhs,
    output logic [FW-1:0]               fpu_d_rhs,
    output fpu_mode_t                   fpu_d_mode,
    input  logic                        fpu_q_trig,
    input  logic [FW-1:0]               fpu_q_res,
    output logic [$clog2(MAX_INFL):0]   inflight,
    output logic                        err_orphan
);

    gpu_id_t           rr_ptr;
    gpu_id_t           head_id;
    logic              tq_full, tq_empty;
    rr_pick_t          pick;
    logic              can_issue, issue, pop, orphan;
    logic [MAX_GPUS-1:0] req_pad;

    assign req_pad = MAX_GPUS'(req_trig);

    always_comb pick = rr_pick(req_pad, rr_ptr, GPUS);

    // A result returning this cycle frees a slot, so a full queue can still issue.
    assign can_issue = fpu_d_ready & (~tq_full | fpu_q_trig);
    // Gating with rst_n keeps every combinational output at 0 during reset.
    assign issue     = rst_n & pick.vld & can_issue;
    assign pop       = rst_n & fpu_q_trig & ~tq_empty;
    assign orphan    = fpu_q_trig & tq_empty;

    always_comb begin
        req_ready  = '0;
        res_trig   = '0;
        fpu_d_lhs  = '0;
        fpu_d_rhs  = '0;
        fpu_d_mode = '0;
        for (int i = 0; i < GPUS; i++) begin
            if (issue && pick.idx == gpu_id_t'(i)) begin
                req_ready[i] = 1'b1;
                fpu_d_lhs    = req_lhs[i*FW +: FW];
                fpu_d_rhs    = req_rhs[i*FW +: FW];
                fpu_d_mode   = req_mode[i*2 +: 2];
            end
            if (pop && head_id == gpu_id_t'(i)) res_trig[i] = 1'b1;
        end
    end

    assign fpu_d_trig = issue;
    assign res_val    = rst_n ? fpu_q_res : '0;

    // With GPUS=1 the winner is always the last index, so rr_ptr stays 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (pick.idx == gpu_id_t'(GPUS-1)) ? '0 : pick.idx + gpu_id_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      err_orphan <= 1'b0;
        else if (orphan) err_orphan <= 1'b1;
    end

    saph_fpu_tagq #(.DEPTH(MAX_INFL)) u_tagq (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (issue),
        .push_id (pick.idx),
        .pop     (pop),
        .head_id (head_id),
        .full    (tq_full),
        .empty   (tq_empty),
        .count   (inflight)
    );

endmodule

// File: tb/tb_saph_fpu_arbiter.sv
module tb_saph_fpu_arbiter;

    localparam int GPUS = 4, MAX_INFL = 4, FW = 32, IW = $clog2(MAX_INFL) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [GPUS-1:0]    req_trig, req_ready, res_trig;
    logic [FW-1:0]      lhs [GPUS];
    logic [FW-1:0]      rhs [GPUS];
    logic [1:0]         mode[GPUS];
    logic [GPUS*FW-1:0] req_lhs, req_rhs;
    logic [GPUS*2-1:0]  req_mode;
    logic [FW-1:0]      res_val, fpu_d_lhs, fpu_d_rhs, fpu_q_res;
    logic [1:0]         fpu_d_mode;
    logic               fpu_d_trig, fpu_d_ready, fpu_q_trig, err_orphan;
    logic [IW-1:0]      inflight;

    always_comb begin
        req_lhs  = '0;
        req_rhs  = '0;
        req_mode = '0;
        for (int i = 0; i < GPUS; i++) begin
            req_lhs[i*FW +: FW] = lhs[i];
            req_rhs[i*FW +: FW] = rhs[i];
            req_mode[i*2 +: 2]  = mode[i];
        end
    end

    saph_fpu_arbiter #(.GPUS(GPUS), .MAX_INFL(MAX_INFL), .FW(FW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_trig(req_trig), .req_ready(req_ready),
        .req_lhs(req_lhs), .req_rhs(req_rhs), .req_mode(req_mode),
        .res_trig(res_trig), .res_val(res_val),
        .fpu_d_trig(fpu_d_trig), .fpu_d_ready(fpu_d_ready),
        .fpu_d_lhs(fpu_d_lhs), .fpu_d_rhs(fpu_d_rhs), .fpu_d_mode(fpu_d_mode),
        .fpu_q_trig(fpu_q_trig), .fpu_q_res(fpu_q_res),
        .inflight(inflight), .err_orphan(err_orphan)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_q[$];      // GPU IDs of outstanding ops, oldest first
    int m_rr = 0;    // next GPU to look at first
    bit m_orphan = 0;

    // Winner under the round-robin rule, -1 if nobody requests.
    function automatic int m_winner();
        for (int k = 0; k < GPUS; k++)
            if (req_trig[(m_rr + k) % GPUS]) return (m_rr + k) % GPUS;
        return -1;
    endfunction

    function automatic bit m_issue();
        bit slot_ok;
        slot_ok = (m_q.size() < MAX_INFL) || fpu_q_trig;
        return fpu_d_ready && slot_ok && (m_winner() >= 0);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_rr = 0;
                m_orphan = 0;
            end else begin
                bit iss;
                int w;
                iss = m_issue();
                w = m_winner();
                if (fpu_q_trig) begin
                    if (m_q.size() == 0) m_orphan = 1;
                    else void'(m_q.pop_front());
                end
                if (iss) begin
                    m_q.push_back(w);
                    m_rr = (w + 1) % GPUS;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("m_rst_ready", req_ready, 0);
                chk("m_rst_dtrig", fpu_d_trig, 0);
                chk("m_rst_rtrig", res_trig, 0);
                chk("m_rst_rval", res_val, 0);
                chk("m_rst_dlhs", fpu_d_lhs, 0);
                chk("m_rst_infl", inflight, 0);
                chk("m_rst_err", err_orphan, 0);
            end else begin
                logic [GPUS-1:0] e_rdy, e_res;
                logic [FW-1:0]   e_l, e_r;
                logic [1:0]      e_m;
                int w;
                e_rdy = '0; e_res = '0; e_l = '0; e_r = '0; e_m = '0;
                w = m_winner();
                if (m_issue()) begin
                    e_rdy[w] = 1'b1;
                    e_l = lhs[w]; e_r = rhs[w]; e_m = mode[w];
                end
                if (fpu_q_trig && m_q.size() > 0) e_res[m_q[0]] = 1'b1;
                chk("m_ready", req_ready, e_rdy);
                chk("m_dtrig", fpu_d_trig, |e_rdy);
                chk("m_dlhs", fpu_d_lhs, e_l);
                chk("m_drhs", fpu_d_rhs, e_r);
                chk("m_dmode", fpu_d_mode, e_m);
                chk("m_rtrig", res_trig, e_res);
                chk("m_rval", res_val, fpu_q_res);
                chk("m_infl", inflight, m_q.size());
                chk("m_err", err_orphan, m_orphan);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input logic [GPUS-1:0] rq, input logic rdy, input logic qt, input logic [FW-1:0] qr);
        @(posedge clk);
        #1;
        req_trig = rq; fpu_d_ready = rdy; fpu_q_trig = qt; fpu_q_res = qr;
        @(negedge clk);
    endtask

    logic [GPUS-1:0] rr_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0, 4'b0, 4'b0, 4'b0};
    int              rr_inf [8] = '{0, 1, 2, 3, 4, 4, 4, 4};
    logic [GPUS-1:0] dr_exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        for (int i = 0; i < GPUS; i++) begin
            lhs[i]  = 32'h1000_0011 * (i + 1);
            rhs[i]  = 32'h0200_0101 * (i + 3);
            mode[i] = 2'(i);
        end
        req_trig = '1; fpu_d_ready = 1'b1; fpu_q_trig = 1'b0; fpu_q_res = '0;

        // Reset with everything requesting.
        repeat (3) begin
            cyc(4'b1111, 1'b1, 1'b0, 32'h0);
            chk("rst_ready", req_ready, 0);
            chk("rst_dtrig", fpu_d_trig, 0);
            chk("rst_infl", inflight, 0);
        end

        // Round-robin: 0,1,2,3 then stall on a full queue.
        @(posedge clk); #1; rst_n = 1'b1; @(negedge clk);
        chk("rr_ready0", req_ready, rr_exp[0]);
        chk("rr_infl0", inflight, rr_inf[0]);
        for (int c = 1; c < 8; c++) begin
            cyc(4'b1111, 1'b1, 1'b0, 32'h0);
            chk($sformatf("rr_ready%0d", c), req_ready, rr_exp[c]);
            chk($sformatf("rr_infl%0d", c), inflight, rr_inf[c]);
        end

        // Full queue with a same-cycle return: GPU1 still issues.
        cyc(4'b0010, 1'b1, 1'b1, 32'hAAAA_0000);
        chk("fp_res", res_trig, 4'b0001);
        chk("fp_ready", req_ready, 4'b0010);
        chk("fp_dlhs", fpu_d_lhs, 32'h2000_0022);
        cyc(4'b0000, 1'b1, 1'b0, 32'h0);
        chk("fp_infl", inflight, 4);

        // Drain: queue holds 1,2,3,1.
        for (int k = 0; k < 4; k++) begin
            cyc(4'b0000, 1'b1, 1'b1, 32'hBEEF_0000 + k);
            chk($sformatf("dr_res%0d", k), res_trig, (k == 3) ? 4'b0010 : dr_exp[k+1]);
            chk($sformatf("dr_val%0d", k), res_val, 32'hBEEF_0000 + k);
        end
        cyc(4'b0000, 1'b1, 1'b0, 32'h0);
        chk("dr_infl", inflight, 0);

        // Routing: GPU2 then GPU0, results two cycles after the first issue.
        lhs[2] = 32'h3F80_0000;
        cyc(4'b0100, 1'b1, 1'b0, 32'h0);
        chk("rt_ready2", req_ready, 4'b0100);
        chk("rt_lhs2", fpu_d_lhs, 32'h3F80_0000);
        chk("rt_mode2", fpu_d_mode, 2'd2);
        cyc(4'b0001, 1'b1, 1'b0, 32'h0);
        chk("rt_ready0", req_ready, 4'b0001);
        cyc(4'b0000, 1'b1, 1'b1, 32'h4000_0000);
        chk("rt_res2", res_trig, 4'b0100);
        chk("rt_val2", res_val, 32'h4000_0000);
        cyc(4'b0000, 1'b1, 1'b1, 32'h4040_0000);
        chk("rt_res0", res_trig, 4'b0001);
        chk("rt_val0", res_val, 32'h4040_0000);

        // Backpressure: pointer sits at GPU1 and must not move.
        repeat (3) begin
            cyc(4'b1111, 1'b0, 1'b0, 32'h0);
            chk("bp_ready", req_ready, 0);
            chk("bp_dtrig", fpu_d_trig, 0);
        end
        cyc(4'b1111, 1'b1, 1'b0, 32'h0);
        chk("bp_grant", req_ready, 4'b0010);
        cyc(4'b0000, 1'b1, 1'b1, 32'h5);
        chk("bp_res", res_trig, 4'b0010);

        // Orphan on an empty queue; sticky.
        cyc(4'b0000, 1'b1, 1'b1, 32'h6);
        chk("or_res", res_trig, 0);
        chk("or_err_pre", err_orphan, 0);
        repeat (3) begin
            cyc(4'b0000, 1'b1, 1'b0, 32'h0);
            chk("or_err", err_orphan, 1);
        end

        // Reset with an op in flight: the returning result becomes an orphan.
        cyc(4'b0001, 1'b1, 1'b0, 32'h0);
        chk("mr_ready", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_trig = '0;
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mr_err_clr", err_orphan, 0);
        chk("mr_infl", inflight, 0);
        cyc(4'b0000, 1'b1, 1'b1, 32'h7);
        chk("mr_res", res_trig, 0);
        cyc(4'b0000, 1'b1, 1'b0, 32'h0);
        chk("mr_err", err_orphan, 1);

        // Only reset clears the sticky flag.
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk);
        chk("fin_err", err_orphan, 0);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
